// File: rtl/fp_align_stage.sv
// ============================================================================
// fp_align_stage
// Operand alignment front end of the single-precision FP add/sub unit.
// Orders operands by magnitude and iteratively right-shifts the smaller one.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_align_stage #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] mant_big,
  output logic [25:0] mant_small,
  output logic        sticky,
  output logic [7:0]  exp_out,
  output logic        sign_out,
  output logic        eff_sub,
  output logic        special
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0] c_step     = 5'(SHIFT_STEP);
  localparam logic [4:0] c_max_dist = 5'd26;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_rem;

  // Operand unpacking: denormals/zero use hidden=0 and effective exponent 1
  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [25:0] w_mant_a;
  logic [25:0] w_mant_b;
  logic        w_a_big;
  logic [7:0]  w_exp_big;
  logic [7:0]  w_exp_small;
  logic [7:0]  w_diff;
  logic [4:0]  w_dist;
  logic        w_special;
  logic        w_capture;

  assign w_exp_a     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
  assign w_exp_b     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
  assign w_mant_a    = {(a[30:23] != 8'd0), a[22:0], 2'b00};
  assign w_mant_b    = {(b[30:23] != 8'd0), b[22:0], 2'b00};
  assign w_a_big     = (a[30:0] >= b[30:0]);
  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
  assign w_diff      = w_exp_big - w_exp_small;
  assign w_dist      = (w_diff > 8'd26) ? c_max_dist : w_diff[4:0];
  assign w_special   = (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF);
  assign w_capture   = in_valid && (r_state == IDLE) && !flush;

  // One shifter step: move by min(SHIFT_STEP, remaining), collect lost bits
  logic [4:0]  w_step;
  logic [25:0] w_mask;
  logic [25:0] w_shifted;
  logic        w_lost;

  assign w_step    = (r_rem < c_step) ? r_rem : c_step;
  assign w_mask    = (26'd1 << w_step) - 26'd1;
  assign w_shifted = mant_small >> w_step;
  assign w_lost    = |(mant_small & w_mask);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_state_nxt = ((w_dist == 5'd0) || w_special) ? DONE : ALIGN;
          end
        end
        ALIGN: begin
          if (r_rem == w_step) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= 5'd0;
      mant_big   <= 26'd0;
      mant_small <= 26'd0;
      sticky     <= 1'b0;
      exp_out    <= 8'd0;
      sign_out   <= 1'b0;
      eff_sub    <= 1'b0;
      special    <= 1'b0;
    end else if (w_capture) begin
      r_rem      <= w_dist;
      mant_big   <= w_a_big ? w_mant_a : w_mant_b;
      mant_small <= w_a_big ? w_mant_b : w_mant_a;
      sticky     <= 1'b0;
      exp_out    <= w_exp_big;
      sign_out   <= w_a_big ? a[31] : (b[31] ^ op);
      eff_sub    <= op ^ a[31] ^ b[31];
      special    <= w_special;
    end else if ((r_state == ALIGN) && !flush) begin
      r_rem      <= r_rem - w_step;
      mant_small <= w_shifted;
      sticky     <= sticky | w_lost;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_align_stage.sv
// ============================================================================
// tb_fp_align_stage
// Directed self-checking bench for fp_align_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_align_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] mant_big;
  logic [25:0] mant_small;
  logic        sticky;
  logic [7:0]  exp_out;
  logic        sign_out;
  logic        eff_sub;
  logic        special;

  int errors = 0;
  int checks = 0;

  fp_align_stage #(.SHIFT_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .sticky     (sticky),
    .exp_out    (exp_out),
    .sign_out   (sign_out),
    .eff_sub    (eff_sub),
    .special    (special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one capture edge; returns at the negedge after it
  task automatic start(input logic [31:0] ta, input logic [31:0] tb_, input logic top);
    @(negedge clk);
    a        = ta;
    b        = tb_;
    op       = top;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges from capture until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (mant_small !== 26'd0) begin errors++; $display("FAIL reset_mant_small got=%h exp=0", mant_small); end
    checks++; if (exp_out !== 8'd0) begin errors++; $display("FAIL reset_exp_out got=%h exp=0", exp_out); end
  endtask

  task automatic test_equal();
    int lat;
    start(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL eq_latency got=%0d exp=1", lat); end
    checks++; if (mant_big !== 26'h2000000) begin errors++; $display("FAIL eq_mant_big got=%h exp=2000000", mant_big); end
    checks++; if (mant_small !== 26'h2000000) begin errors++; $display("FAIL eq_mant_small got=%h exp=2000000", mant_small); end
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL eq_sticky got=%b exp=0", sticky); end
    checks++; if (exp_out !== 8'd127) begin errors++; $display("FAIL eq_exp got=%0d exp=127", exp_out); end
    checks++; if (eff_sub !== 1'b0) begin errors++; $display("FAIL eq_eff_sub got=%b exp=0", eff_sub); end
    checks++; if (sign_out !== 1'b0) begin errors++; $display("FAIL eq_sign got=%b exp=0", sign_out); end
    checks++; if (special !== 1'b0) begin errors++; $display("FAIL eq_special got=%b exp=0", special); end
    complete();
  endtask

  task automatic test_swap();
    int lat;
    start(32'h3F800000, 32'h40000000, 1'b1);
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL swap_latency got=%0d exp=2", lat); end
    checks++; if (mant_big !== 26'h2000000) begin errors++; $display("FAIL swap_mant_big got=%h exp=2000000", mant_big); end
    checks++; if (mant_small !== 26'h1000000) begin errors++; $display("FAIL swap_mant_small got=%h exp=1000000", mant_small); end
    checks++; if (exp_out !== 8'd128) begin errors++; $display("FAIL swap_exp got=%0d exp=128", exp_out); end
    checks++; if (eff_sub !== 1'b1) begin errors++; $display("FAIL swap_eff_sub got=%b exp=1", eff_sub); end
    checks++; if (sign_out !== 1'b1) begin errors++; $display("FAIL swap_sign got=%b exp=1", sign_out); end
    complete();
  endtask

  task automatic test_d24();
    int lat;
    start(32'h4B800000, 32'h3F800001, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL d24_latency got=%0d exp=7", lat); end
    checks++; if (mant_small !== 26'h0000002) begin errors++; $display("FAIL d24_mant_small got=%h exp=0000002", mant_small); end
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL d24_sticky got=%b exp=1", sticky); end
    checks++; if (exp_out !== 8'd151) begin errors++; $display("FAIL d24_exp got=%0d exp=151", exp_out); end
    complete();
  endtask

  task automatic test_clamp();
    int lat;
    start(32'h4F800000, 32'h3F800000, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL clamp_latency got=%0d exp=8", lat); end
    checks++; if (mant_small !== 26'd0) begin errors++; $display("FAIL clamp_mant_small got=%h exp=0", mant_small); end
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL clamp_sticky got=%b exp=1", sticky); end
    checks++; if (exp_out !== 8'd159) begin errors++; $display("FAIL clamp_exp got=%0d exp=159", exp_out); end
    complete();
  endtask

  task automatic test_sticky_clear();
    int lat;
    start(32'h3F800000, 32'h3F800000, 1'b0);
    wait_valid(lat);
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear got=%b exp=0", sticky); end
    complete();
  endtask

  task automatic test_special();
    int lat;
    start(32'h7F800000, 32'h3F800000, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency got=%0d exp=1", lat); end
    checks++; if (special !== 1'b1) begin errors++; $display("FAIL special_flag got=%b exp=1", special); end
    checks++; if (exp_out !== 8'd255) begin errors++; $display("FAIL special_exp got=%0d exp=255", exp_out); end
    complete();
  endtask

  task automatic test_backpressure();
    int lat;
    start(32'h4B800000, 32'h3F800001, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (mant_small !== 26'h0000002) begin errors++; $display("FAIL bp_mant_small[%0d] got=%h exp=0000002", i, mant_small); end
    end
    complete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    start(32'h4F800000, 32'h3F800000, 1'b0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    checks++; if (exp_out !== 8'd0) begin errors++; $display("FAIL areset_exp got=%0d exp=0", exp_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_flush();
    start(32'h4F800000, 32'h3F800000, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (exp_out !== 8'd159) begin errors++; $display("FAIL flush_retain_exp got=%0d exp=159", exp_out); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_idle got=%b exp=0", out_valid); end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    op        = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_equal();
    test_swap();
    test_d24();
    test_clamp();
    test_sticky_clear();
    test_special();
    test_backpressure();
    test_async_reset();
    test_flush();
    test_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
